// File: rtl/halfduplex_msg_serdes_if.sv
// halfduplex_msg_serdes_if: message-side handshake and status bundle for the serdes
interface halfduplex_msg_serdes_if #(
   parameter int MSG_WIDTH = 4,
   parameter int CH_NUM = 4
);
   logic [CH_NUM*MSG_WIDTH-1:0] tx_msg;
   logic [CH_NUM*MSG_WIDTH-1:0] rx_msg;
   logic tx_valid;
   logic tx_ready;
   logic rx_start;
   logic rx_valid;
   logic drive_en;
   logic busy;
   modport master(output tx_msg, tx_valid, rx_start, input tx_ready, rx_msg, rx_valid, drive_en, busy);
   modport slave(input tx_msg, tx_valid, rx_start, output tx_ready, rx_msg, rx_valid, drive_en, busy);
endinterface

// File: rtl/halfduplex_msg_serdes.sv
// halfduplex_msg_serdes: lock-step multi-lane half-duplex message serialiser/deserialiser
module halfduplex_msg_serdes #(
   parameter int MSG_WIDTH = 4,
   parameter int CH_NUM = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic sys_clk,
   input logic rst,
   inout wire [CH_NUM-1:0] serial_io,
   halfduplex_msg_serdes_if.slave bus
);
   localparam int CW = $clog2(MSG_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(MSG_WIDTH - 1);
   typedef enum logic [1:0] {IDLE, TX, RX} state_t;
   state_t state;
   logic [CW-1:0] bit_cnt;
   logic [CH_NUM-1:0][MSG_WIDTH-1:0] tx_sr, rx_sr, tx_nxt, rx_nxt;
   logic [CH_NUM-1:0] tx_bit;
   always_comb begin
      tx_bit = '0;
      tx_nxt = '0;
      rx_nxt = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         tx_bit[c] = MSB_FIRST ? tx_sr[c][MSG_WIDTH-1] : tx_sr[c][0];
         tx_nxt[c] = MSB_FIRST ? tx_sr[c] << 1 : tx_sr[c] >> 1;
         rx_nxt[c] = MSB_FIRST ? {rx_sr[c][MSG_WIDTH-2:0], serial_io[c]} : {serial_io[c], rx_sr[c][MSG_WIDTH-1:1]};
      end
   end
   assign serial_io = bus.drive_en ? tx_bit : {CH_NUM{1'bz}};
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= IDLE;
         bit_cnt <= '0;
         tx_sr <= '0;
         rx_sr <= '0;
         bus.rx_msg <= '0;
         bus.rx_valid <= 1'b0;
         bus.drive_en <= 1'b0;
         bus.busy <= 1'b0;
         bus.tx_ready <= 1'b1;
      end else begin
         bus.rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (bus.tx_valid) begin
                  state <= TX;
                  tx_sr <= bus.tx_msg;
                  bus.drive_en <= 1'b1;
                  bus.busy <= 1'b1;
                  bus.tx_ready <= 1'b0;
               end else if (bus.rx_start) begin
                  state <= RX;
                  bus.busy <= 1'b1;
                  bus.tx_ready <= 1'b0;
               end
            end
            TX: begin
               tx_sr <= tx_nxt;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST) begin
                  state <= IDLE;
                  bus.drive_en <= 1'b0;
                  bus.busy <= 1'b0;
                  bus.tx_ready <= 1'b1;
               end
            end
            RX: begin
               rx_sr <= rx_nxt;
               bit_cnt <= bit_cnt + 1'b1;
               // last sample goes straight into rx_msg so it is visible in the first IDLE cycle
               if (bit_cnt == LAST) begin
                  state <= IDLE;
                  bus.rx_msg <= rx_nxt;
                  bus.rx_valid <= 1'b1;
                  bus.busy <= 1'b0;
                  bus.tx_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_halfduplex_msg_serdes.sv
// tb_halfduplex_msg_serdes: table, corner-case and random checks of MSB-first and LSB-first instances
module tb_halfduplex_msg_serdes;
   localparam int M = 4;
   localparam int CH = 2;
   localparam int W = M * CH;
   logic sys_clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] tx_msg = '0;
   logic tx_valid = 1'b0;
   logic rx_start = 1'b0;
   logic tb_oe = 1'b0;
   logic [CH-1:0] tb_bits = '0;
   wire [CH-1:0] sio1, sio0;
   int tests = 0;
   int fails = 0;
   always #5 sys_clk = ~sys_clk;
   halfduplex_msg_serdes_if #(.MSG_WIDTH(M), .CH_NUM(CH)) if1 ();
   halfduplex_msg_serdes_if #(.MSG_WIDTH(M), .CH_NUM(CH)) if0 ();
   assign if1.tx_msg = tx_msg;
   assign if1.tx_valid = tx_valid;
   assign if1.rx_start = rx_start;
   assign if0.tx_msg = tx_msg;
   assign if0.tx_valid = tx_valid;
   assign if0.rx_start = rx_start;
   assign sio1 = tb_oe ? tb_bits : {CH{1'bz}};
   assign sio0 = tb_oe ? tb_bits : {CH{1'bz}};
   halfduplex_msg_serdes #(.MSG_WIDTH(M), .CH_NUM(CH), .MSB_FIRST(1'b1)) u_msb (
      .sys_clk(sys_clk), .rst(rst), .serial_io(sio1), .bus(if1));
   halfduplex_msg_serdes #(.MSG_WIDTH(M), .CH_NUM(CH), .MSB_FIRST(1'b0)) u_lsb (
      .sys_clk(sys_clk), .rst(rst), .serial_io(sio0), .bus(if0));
   typedef struct {
      logic [W-1:0] msg;
      logic [W-1:0] e1;
      logic [W-1:0] e0;
   } tx_vec_t;
   typedef struct {
      logic [W-1:0] line;
      logic [W-1:0] e1;
      logic [W-1:0] e0;
   } rx_vec_t;
   tx_vec_t tx_tab [2];
   rx_vec_t rx_tab [3];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // line sequence: cycle i occupies bits [i*CH +: CH], lane c at bit c
   function automatic logic [W-1:0] tx_seq(input logic [W-1:0] msg, input bit msb);
      logic [W-1:0] s = '0;
      for (int i = 0; i < M; i++)
         for (int c = 0; c < CH; c++)
            s[i*CH+c] = msb ? msg[c*M+M-1-i] : msg[c*M+i];
      return s;
   endfunction
   // line bits: lane c's i-th sent bit is line[c*M+i]
   function automatic logic [W-1:0] rx_model(input logic [W-1:0] line, input bit msb);
      logic [W-1:0] r = '0;
      for (int c = 0; c < CH; c++)
         for (int i = 0; i < M; i++)
            r[c*M + (msb ? M-1-i : i)] = line[c*M+i];
      return r;
   endfunction
   task automatic run_tx(input logic [W-1:0] msg, input logic [W-1:0] e1, input logic [W-1:0] e0, input logic rs);
      tx_msg = msg;
      tx_valid = 1'b1;
      rx_start = rs;
      @(negedge sys_clk);
      tx_valid = 1'b0;
      for (int i = 0; i < M; i++) begin
         chk("tx_drive_en_msb", 32'(if1.drive_en), 1);
         chk("tx_drive_en_lsb", 32'(if0.drive_en), 1);
         chk("tx_busy", 32'(if1.busy), 1);
         chk("tx_ready_low", 32'(if1.tx_ready), 0);
         chk("tx_line_msb", 32'(sio1), 32'(e1[i*CH+:CH]));
         chk("tx_line_lsb", 32'(sio0), 32'(e0[i*CH+:CH]));
         chk("tx_no_rx_valid", 32'(if1.rx_valid | if0.rx_valid), 0);
         @(negedge sys_clk);
      end
      rx_start = 1'b0;
      chk("tx_end_drive_en", 32'(if1.drive_en | if0.drive_en), 0);
      chk("tx_end_ready", 32'(if1.tx_ready & if0.tx_ready), 1);
      chk("tx_end_busy", 32'(if1.busy | if0.busy), 0);
   endtask
   task automatic run_rx(input logic [W-1:0] line, input logic [W-1:0] e1, input logic [W-1:0] e0);
      rx_start = 1'b1;
      @(negedge sys_clk);
      rx_start = 1'b0;
      tb_oe = 1'b1;
      for (int i = 0; i < M; i++) begin
         for (int c = 0; c < CH; c++) tb_bits[c] = line[c*M+i];
         chk("rx_busy", 32'(if1.busy & if0.busy), 1);
         chk("rx_drive_en", 32'(if1.drive_en | if0.drive_en), 0);
         chk("rx_valid_early", 32'(if1.rx_valid | if0.rx_valid), 0);
         @(negedge sys_clk);
      end
      tb_oe = 1'b0;
      chk("rx_valid_msb", 32'(if1.rx_valid), 1);
      chk("rx_valid_lsb", 32'(if0.rx_valid), 1);
      chk("rx_msg_msb", 32'(if1.rx_msg), 32'(e1));
      chk("rx_msg_lsb", 32'(if0.rx_msg), 32'(e0));
      chk("rx_end_ready", 32'(if1.tx_ready & if0.tx_ready), 1);
      @(negedge sys_clk);
      chk("rx_valid_pulse", 32'(if1.rx_valid | if0.rx_valid), 0);
      chk("rx_msg_hold", 32'(if1.rx_msg), 32'(e1));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [W-1:0] r;
      tx_tab[0] = '{8'hA5, 8'h66, 8'h99};
      tx_tab[1] = '{8'h3C, 8'hA5, 8'h5A};
      rx_tab[0] = '{8'h6F, 8'h6F, 8'h6F};
      rx_tab[1] = '{8'h13, 8'h8C, 8'h13};
      rx_tab[2] = '{8'hD4, 8'hB2, 8'hD4};
      repeat (3) @(negedge sys_clk);
      chk("rst_drive_en", 32'(if1.drive_en | if0.drive_en), 0);
      chk("rst_rx_valid", 32'(if1.rx_valid | if0.rx_valid), 0);
      chk("rst_rx_msg", 32'({if1.rx_msg, if0.rx_msg}), 0);
      chk("rst_busy", 32'(if1.busy | if0.busy), 0);
      rst = 1'b0;
      @(negedge sys_clk);
      chk("post_rst_ready", 32'(if1.tx_ready & if0.tx_ready), 1);
      chk("post_rst_drive_en", 32'(if1.drive_en | if0.drive_en), 0);
      for (int t = 0; t < 2; t++) run_tx(tx_tab[t].msg, tx_tab[t].e1, tx_tab[t].e0, 1'b0);
      for (int t = 0; t < 3; t++) run_rx(rx_tab[t].line, rx_tab[t].e1, rx_tab[t].e0);
      run_tx(8'h5A, tx_seq(8'h5A, 1'b1), tx_seq(8'h5A, 1'b0), 1'b0);
      chk("tx_keeps_rx_msg_msb", 32'(if1.rx_msg), 32'h B2);
      chk("tx_keeps_rx_msg_lsb", 32'(if0.rx_msg), 32'h D4);
      // tx_valid and rx_start together, rx_start held through the TX: TX only
      run_tx(8'hC3, tx_seq(8'hC3, 1'b1), tx_seq(8'hC3, 1'b0), 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         chk("no_rx_after_tx_busy", 32'(if1.busy | if0.busy), 0);
         chk("no_rx_after_tx_valid", 32'(if1.rx_valid | if0.rx_valid), 0);
      end
      tx_msg = 8'hA5;
      tx_valid = 1'b1;
      @(negedge sys_clk);
      for (int i = 0; i < 3 * (M + 1); i++) begin
         chk("b2b_drive_en", 32'(if1.drive_en), 32'((i % (M + 1)) != M));
         chk("b2b_ready", 32'(if1.tx_ready), 32'((i % (M + 1)) == M));
         if (i % (M + 1) != M) chk("b2b_line", 32'(sio1), 32'(8'h66 >> ((i % (M + 1)) * CH) & 8'h3));
         @(negedge sys_clk);
      end
      tx_valid = 1'b0;
      repeat (M) @(negedge sys_clk);
      chk("b2b_drain", 32'(if1.busy | if0.busy), 0);
      rx_start = 1'b1;
      @(negedge sys_clk);
      rx_start = 1'b0;
      tb_oe = 1'b1;
      tb_bits = 2'b11;
      repeat (2) @(negedge sys_clk);
      rst = 1'b1;
      @(negedge sys_clk);
      rst = 1'b0;
      tb_oe = 1'b0;
      chk("abort_busy", 32'(if1.busy | if0.busy), 0);
      chk("abort_drive_en", 32'(if1.drive_en | if0.drive_en), 0);
      chk("abort_rx_msg", 32'({if1.rx_msg, if0.rx_msg}), 0);
      chk("abort_ready", 32'(if1.tx_ready & if0.tx_ready), 1);
      for (int i = 0; i < M + 1; i++) begin
         chk("abort_no_rx_valid", 32'(if1.rx_valid | if0.rx_valid), 0);
         @(negedge sys_clk);
      end
      run_tx(8'h3C, 8'hA5, 8'h5A, 1'b0);
      for (int n = 0; n < 24; n++) begin
         r = W'($urandom);
         if ($urandom_range(0, 1) == 1) run_tx(r, tx_seq(r, 1'b1), tx_seq(r, 1'b0), 1'b0);
         else run_rx(r, rx_model(r, 1'b1), rx_model(r, 1'b0));
         repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
